// File: rtl/berger_one_scrubber.sv
// Background Berger-code scrubber: walks every word of the codeword store on the
// shared read port, recomputes popcount(data) and reports mismatching words.
module berger_one_scrubber #(
    parameter int DATA_W = 8,
    parameter int CHK_W  = 4,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    host_req,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W+CHK_W-1:0] mem_rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err_valid,
    output logic [ADDR_W-1:0]       err_addr,
    output logic [CNT_W-1:0]        err_count,
    output logic                    first_err_vld,
    output logic [ADDR_W-1:0]       first_err_addr,
    output logic [1:0]              dbg_state
);

    // Handshake: a read is issued in any cycle with mem_rd_en=1; the memory
    // answers on mem_rd_data exactly one cycle later, no back-pressure.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                drain_q, drain_d;
    logic                scan_clr;

    logic                rd_vld_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                err_valid_q;
    logic [ADDR_W-1:0]   err_addr_q;
    logic [CNT_W-1:0]    err_count_q;
    logic                first_vld_q;
    logic [ADDR_W-1:0]   first_addr_q;
    logic                mismatch;

    function automatic logic [CHK_W-1:0] popcount(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + CHK_W'(d[i]);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        drain_d   = drain_q;
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        scan_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SCAN;
                    ptr_d    = '0;
                    scan_clr = 1'b1;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (!host_req) begin
                    mem_rd_en = 1'b1;
                    ptr_d     = ptr_q + 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                // Two cycles: one for the read data, one for the check result.
                busy    = 1'b1;
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mismatch = rd_vld_q &&
        (popcount(mem_rd_data[CHK_W+DATA_W-1:CHK_W]) != mem_rd_data[CHK_W-1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_vld_q     <= 1'b0;
            rd_addr_q    <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
            err_count_q  <= '0;
            first_vld_q  <= 1'b0;
            first_addr_q <= '0;
        end else begin
            rd_vld_q    <= mem_rd_en;
            rd_addr_q   <= mem_addr;
            err_valid_q <= mismatch;
            if (mismatch) begin
                err_addr_q <= rd_addr_q;
            end
            if (scan_clr) begin
                err_count_q  <= '0;
                first_vld_q  <= 1'b0;
                first_addr_q <= '0;
            end else if (mismatch) begin
                err_count_q <= err_count_q + 1'b1;
                if (!first_vld_q) begin
                    first_vld_q  <= 1'b1;
                    first_addr_q <= rd_addr_q;
                end
            end
        end
    end

    assign mem_addr       = ptr_q;
    assign err_valid      = err_valid_q;
    assign err_addr       = err_addr_q;
    assign err_count      = err_count_q;
    assign first_err_vld  = first_vld_q;
    assign first_err_addr = first_addr_q;
    assign dbg_state      = state_q;

endmodule
